// File: rtl/instruction_fetch_controller_pkg.sv
// Shared types and constants for the two-byte instruction fetch path.
// State encodings, IR half selects and default parameter values.
package instruction_fetch_controller_pkg;

  typedef enum logic [1:0] {
    FS_IDLE     = 2'd0,
    FS_FETCH_LO = 2'd1,
    FS_FETCH_HI = 2'd2,
    FS_VALID    = 2'd3
  } fetch_state_e;

  localparam logic IR_LOW  = 1'b0;
  localparam logic IR_HIGH = 1'b1;

  localparam int DEFAULT_AW      = 16;
  localparam int DEFAULT_TIMEOUT = 15;

  // Counter width; a single bit is the floor so TIMEOUT=1 still elaborates.
  function automatic int cnt_width(input int t);
    return (t <= 2) ? 1 : $clog2(t);
  endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Per-byte wait counter for the fetch sequencer.
// Flags the last permitted wait cycle.
module fetch_timeout_counter
  import instruction_fetch_controller_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Clear wins over enable; counting is synchronous.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/instruction_fetch_controller.sv
// Two-byte instruction fetch sequencer: low byte then high byte
// into the IR, with PC ownership, timeout and valid/ack handshake.
module instruction_fetch_controller
  import instruction_fetch_controller_pkg::*;
#(
  parameter int          AW       = DEFAULT_AW,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int          TIMEOUT  = DEFAULT_TIMEOUT
) (
  input  logic          Clock,
  input  logic          ResetN,
  input  logic          Start,
  input  logic          PCLoad,
  input  logic [AW-1:0] PCLoadValue,
  output logic          MemRead,
  output logic [AW-1:0] MemAddr,
  input  logic          MemReady,
  input  logic [7:0]    MemData,
  output logic [7:0]    IRData,
  output logic          IRWrite,
  output logic          IRLH,
  output logic          InstrValid,
  input  logic          InstrAck,
  output logic          Busy,
  output logic          Error
);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          error_q, error_d;
  logic          cnt_clr;
  logic          cnt_en;
  logic          expired;
  logic          fetching;

  assign fetching = (state_q == FS_FETCH_LO) ||
                    (state_q == FS_FETCH_HI);

  fetch_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (Clock),
    .rst_n  (ResetN),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .expired(expired)
  );

  // Next state, PC and error flag; PC redirects only when not fetching.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    error_d = error_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      FS_IDLE: begin
        if (PCLoad) pc_d = PCLoadValue;
        if (Start) begin
          state_d = FS_FETCH_LO;
          error_d = 1'b0;
          cnt_clr = 1'b1;
        end
      end
      FS_FETCH_LO,
      FS_FETCH_HI: begin
        if (MemReady) begin
          pc_d    = pc_q + AW'(1);
          cnt_clr = 1'b1;
          state_d = (state_q == FS_FETCH_LO) ?
                    FS_FETCH_HI : FS_VALID;
        end else if (expired) begin
          error_d = 1'b1;
          cnt_clr = 1'b1;
          state_d = FS_IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      FS_VALID: begin
        if (PCLoad) pc_d = PCLoadValue;
        if (InstrAck) begin
          if (Start) begin
            state_d = FS_FETCH_LO;
            error_d = 1'b0;
            cnt_clr = 1'b1;
          end else begin
            state_d = FS_IDLE;
          end
        end
      end
      default: state_d = FS_IDLE;
    endcase
  end

  // State, PC and sticky error registers.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= FS_IDLE;
      pc_q    <= RESET_PC;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      error_q <= error_d;
    end
  end

  assign MemRead    = fetching;
  assign MemAddr    = pc_q;
  assign Busy       = fetching;
  assign IRData     = MemData;
  assign IRWrite    = fetching && MemReady;
  assign IRLH       = (state_q == FS_FETCH_HI) ? IR_HIGH : IR_LOW;
  assign InstrValid = (state_q == FS_VALID);
  assign Error      = error_q;

endmodule
